// File: rtl/pol_ofm_writer.sv
// Pooled-output writer: takes pooled vectors from the pooling stage, splits
// each into SRAM-width beats and streams them to the GLB write port at
// consecutive word addresses, pulsing Done once the configured layer is out.
module pol_ofm_writer #(
   parameter int IDX_WIDTH      = 10,
   parameter int ACT_WIDTH      = 8,
   parameter int POOL_COMP_CORE = 64,
   parameter int CHN_WIDTH      = 12,
   parameter int SRAM_WIDTH     = 256,
   parameter int ADDR_WIDTH     = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                CCUPOW_Rst,
   input  logic                                CCUPOW_CfgVld,
   output logic                                POWCCU_CfgRdy,
   input  logic [IDX_WIDTH-1:0]                CCUPOW_CfgNop,
   input  logic [CHN_WIDTH-1:0]                CCUPOW_CfgChi,
   input  logic [ADDR_WIDTH-1:0]               CCUPOW_CfgBaseAddr,
   input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLPOW_Ofm,
   input  logic                                POLPOW_OfmVld,
   output logic                                POWPOL_OfmRdy,
   output logic [ADDR_WIDTH-1:0]               POWGLB_WrAddr,
   output logic [SRAM_WIDTH-1:0]               POWGLB_WrDat,
   output logic                                POWGLB_WrVld,
   input  logic                                GLBPOW_WrRdy,
   output logic                                POWCCU_Done
);

   localparam int VEC_WIDTH = ACT_WIDTH * POOL_COMP_CORE;
   localparam int BEATS     = VEC_WIDTH / SRAM_WIDTH;
   localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TOTAL_W   = IDX_WIDTH + CHN_WIDTH;
   localparam int CHN_W1    = CHN_WIDTH + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   stateT                  state;
   stateT                  nextState;
   logic                   isBusy;
   logic [TOTAL_W-1:0]     totalReg;
   logic [TOTAL_W-1:0]     accCnt;
   logic [ADDR_WIDTH-1:0]  baseReg;
   logic [ADDR_WIDTH-1:0]  wrCnt;
   logic [BEAT_W-1:0]      beatCnt;
   logic [VEC_WIDTH-1:0]   bufData;
   logic                   bufValid;

   logic [CHN_W1-1:0]      chiRound;
   logic [CHN_W1-1:0]      slcCalc;
   logic [TOTAL_W-1:0]     totalCalc;
   logic                   cfgFire;
   logic                   wrFire;
   logic                   lastBeat;
   logic                   ofmFire;
   logic                   finalBeat;

   // Slice count rounds the channel count up to whole pooled vectors; the
   // layer total is points times slices, computed from the live config bus.
   assign chiRound  = {1'b0, CCUPOW_CfgChi} + CHN_W1'(POOL_COMP_CORE - 1);
   assign slcCalc   = chiRound / CHN_W1'(POOL_COMP_CORE);
   assign totalCalc = TOTAL_W'(CCUPOW_CfgNop) * TOTAL_W'(slcCalc);

   assign cfgFire   = CCUPOW_CfgVld & POWCCU_CfgRdy;
   assign wrFire    = bufValid & GLBPOW_WrRdy;
   assign lastBeat  = (beatCnt == LAST_BEAT);
   assign finalBeat = wrFire & lastBeat & (accCnt == totalReg);

   // The buffer may be refilled in the same cycle its last beat leaves, which
   // keeps the write port busy every cycle when the GLB never stalls.
   assign POWPOL_OfmRdy = isBusy & (accCnt < totalReg) & (~bufValid | (lastBeat & wrFire));
   assign ofmFire       = POLPOW_OfmVld & POWPOL_OfmRdy;

   assign POWGLB_WrVld  = bufValid;
   assign POWGLB_WrAddr = baseReg + wrCnt;
   assign POWGLB_WrDat  = bufData[SRAM_WIDTH*beatCnt +: SRAM_WIDTH];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; the CCU soft reset overrides every transition.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (cfgFire) nextState = (totalCalc == '0) ? DONE : BUSY;
         BUSY:    if (finalBeat) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (CCUPOW_Rst) nextState = IDLE;
   end

   // State-decoded outputs.
   always_comb begin
      POWCCU_CfgRdy = 1'b0;
      POWCCU_Done   = 1'b0;
      isBusy        = 1'b0;
      case (state)
         IDLE:    POWCCU_CfgRdy = 1'b1;
         BUSY:    isBusy        = 1'b1;
         DONE:    POWCCU_Done   = 1'b1;
         default: POWCCU_CfgRdy = 1'b0;
      endcase
   end

   // Datapath: config capture, one-entry vector buffer, beat and address counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         totalReg <= '0;
         baseReg  <= '0;
         accCnt   <= '0;
         wrCnt    <= '0;
         beatCnt  <= '0;
         bufData  <= '0;
         bufValid <= 1'b0;
      end else if (CCUPOW_Rst) begin
         accCnt   <= '0;
         wrCnt    <= '0;
         beatCnt  <= '0;
         bufValid <= 1'b0;
      end else begin
         if (cfgFire) begin
            totalReg <= totalCalc;
            baseReg  <= CCUPOW_CfgBaseAddr;
            accCnt   <= '0;
            wrCnt    <= '0;
            beatCnt  <= '0;
         end
         if (wrFire) begin
            wrCnt   <= wrCnt + ADDR_WIDTH'(1);
            beatCnt <= lastBeat ? '0 : beatCnt + BEAT_W'(1);
         end
         if (ofmFire) begin
            bufData  <= POLPOW_Ofm;
            bufValid <= 1'b1;
            accCnt   <= accCnt + TOTAL_W'(1);
         end else if (wrFire & lastBeat) begin
            bufValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pol_ofm_writer.sv
// Self-checking bench for pol_ofm_writer: a table of layer configurations
// plus random layers, checked against a scoreboard of expected GLB writes,
// and a hand-written soft-reset sequence.
module tb_pol_ofm_writer;

   localparam int VW = 512;
   localparam int SW = 256;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ccuRst = 1'b0;
   logic           cfgVld = 1'b0;
   logic           cfgRdy;
   logic [9:0]     cfgNop = '0;
   logic [11:0]    cfgChi = '0;
   logic [15:0]    cfgBase = '0;
   logic [VW-1:0]  ofm = '0;
   logic           ofmVld = 1'b0;
   logic           ofmRdy;
   logic [15:0]    wrAddr;
   logic [SW-1:0]  wrDat;
   logic           wrVld;
   logic           wrRdy = 1'b0;
   logic           done;

   typedef struct {
      logic [15:0]   addr;
      logic [SW-1:0] data;
   } writeT;

   typedef struct {
      int          nop;
      int          chi;
      logic [15:0] base;
      int          rdyMode;
      bit          extraVld;
      int          expWrites;
      int          expAccepts;
   } layerVecT;

   writeT expQ[$];
   int    totalChecks = 0;
   int    badChecks = 0;
   int    cyc = 0;
   int    rdyMode = 3;
   int    writeCnt = 0;
   int    acceptCnt = 0;
   int    doneCnt = 0;
   int    rdyHighCnt = 0;
   int    lastWrCyc = 0;
   int    doneCyc = 0;
   int    cfgCyc = 0;
   bit    holdPending = 1'b0;
   logic [15:0]   holdAddr;
   logic [SW-1:0] holdDat;

   pol_ofm_writer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .CCUPOW_Rst         (ccuRst),
      .CCUPOW_CfgVld      (cfgVld),
      .POWCCU_CfgRdy      (cfgRdy),
      .CCUPOW_CfgNop      (cfgNop),
      .CCUPOW_CfgChi      (cfgChi),
      .CCUPOW_CfgBaseAddr (cfgBase),
      .POLPOW_Ofm         (ofm),
      .POLPOW_OfmVld      (ofmVld),
      .POWPOL_OfmRdy      (ofmRdy),
      .POWGLB_WrAddr      (wrAddr),
      .POWGLB_WrDat       (wrDat),
      .POWGLB_WrVld       (wrVld),
      .GLBPOW_WrRdy       (wrRdy),
      .POWCCU_Done        (done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   // GLB ready pattern: 0 always ready, 1 toggling, 2 random, else stalled.
   always @(posedge clk) begin
      #1;
      case (rdyMode)
         0:       wrRdy = 1'b1;
         1:       wrRdy = ~wrRdy;
         2:       wrRdy = 1'($urandom_range(0, 1));
         default: wrRdy = 1'b0;
      endcase
   end

   task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard the write port, count handshakes and Done pulses,
   // and require a stalled write to hold its address and data.
   always @(negedge clk) begin
      if (holdPending) begin
         checkOutput("hold vld", wrVld, 1'b1);
         checkOutput("hold addr", wrAddr, holdAddr);
         checkOutput("hold data", wrDat, holdDat);
      end
      holdPending = wrVld & ~wrRdy & ~ccuRst;
      holdAddr    = wrAddr;
      holdDat     = wrDat;
      if (wrVld && wrRdy) begin
         writeCnt++;
         lastWrCyc = cyc;
         if (expQ.size() == 0) begin
            checkOutput("unexpected write", 1'b1, 1'b0);
         end else begin
            writeT e;
            e = expQ.pop_front();
            checkOutput("write addr", wrAddr, e.addr);
            checkOutput("write data", wrDat, e.data);
         end
      end
      if (ofmVld && ofmRdy) acceptCnt++;
      if (ofmRdy) rdyHighCnt++;
      if (done) begin
         doneCnt++;
         doneCyc = cyc;
      end
   end

   task automatic clearCounters();
      writeCnt   = 0;
      acceptCnt  = 0;
      doneCnt    = 0;
      rdyHighCnt = 0;
   endtask

   // Build the expected write list: beats in order at consecutive addresses.
   task automatic modelLayer(input int nv, input logic [15:0] base, output logic [VW-1:0] vecs[$]);
      logic [15:0] a;
      logic [VW-1:0] v;
      a = base;
      vecs.delete();
      for (int i = 0; i < nv; i++) begin
         for (int w = 0; w < VW/32; w++) v[32*w +: 32] = $urandom();
         vecs.push_back(v);
         for (int b = 0; b < VW/SW; b++) begin
            writeT e;
            e.addr = a;
            e.data = v[SW*b +: SW];
            expQ.push_back(e);
            a = a + 16'd1;
         end
      end
   endtask

   task automatic applyStimulus(input int nop, input int chi, input logic [15:0] base);
      int guard;
      @(posedge clk); #1;
      cfgVld  = 1'b1;
      cfgNop  = 10'(nop);
      cfgChi  = 12'(chi);
      cfgBase = base;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!cfgRdy && guard < 50);
      if (!cfgRdy) checkOutput("cfg timeout", 1'b0, 1'b1);
      cfgCyc = cyc;
      @(posedge clk); #1;
      cfgVld = 1'b0;
   endtask

   task automatic sendVector(input logic [VW-1:0] v);
      int guard;
      ofm    = v;
      ofmVld = 1'b1;
      guard  = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!ofmRdy && guard < 200);
      if (!ofmRdy) checkOutput("ofm timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic runLayer(input layerVecT lv);
      logic [VW-1:0] vecs[$];
      int nv;
      int guard;
      rdyMode = lv.rdyMode;
      clearCounters();
      nv = lv.nop * ((lv.chi + 63) / 64);
      modelLayer(nv, lv.base, vecs);
      applyStimulus(lv.nop, lv.chi, lv.base);
      foreach (vecs[i]) sendVector(vecs[i]);
      if (lv.extraVld) begin
         for (int w = 0; w < VW/32; w++) ofm[32*w +: 32] = $urandom();
         ofmVld = 1'b1;
      end else begin
         ofmVld = 1'b0;
      end
      guard = 0;
      while (doneCnt == 0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("done seen", doneCnt, 1);
      if (nv == 0) checkOutput("done latency cfg", doneCyc - cfgCyc, 1);
      else         checkOutput("done latency wr", doneCyc - lastWrCyc, 1);
      @(negedge clk);
      checkOutput("done pulse width", done, 1'b0);
      checkOutput("cfgRdy after done", cfgRdy, 1'b1);
      repeat (6) @(negedge clk);
      ofmVld = 1'b0;
      checkOutput("write count", writeCnt, lv.expWrites);
      checkOutput("accept count", acceptCnt, lv.expAccepts);
      checkOutput("done count", doneCnt, 1);
      checkOutput("expected left", expQ.size(), 0);
      if (lv.expAccepts == 0) checkOutput("ofmRdy never high", rdyHighCnt, 0);
      expQ.delete();
   endtask

   layerVecT table0[6];

   initial begin
      layerVecT lv;
      logic [VW-1:0] vecs[$];
      int guard;

      table0[0] = '{nop: 2, chi: 64,  base: 16'h0100, rdyMode: 0, extraVld: 0, expWrites: 4, expAccepts: 2};
      table0[1] = '{nop: 1, chi: 130, base: 16'h0040, rdyMode: 1, extraVld: 0, expWrites: 6, expAccepts: 3};
      table0[2] = '{nop: 0, chi: 64,  base: 16'h0010, rdyMode: 0, extraVld: 0, expWrites: 0, expAccepts: 0};
      table0[3] = '{nop: 2, chi: 64,  base: 16'hFFFE, rdyMode: 0, extraVld: 0, expWrites: 4, expAccepts: 2};
      table0[4] = '{nop: 2, chi: 64,  base: 16'h0080, rdyMode: 0, extraVld: 1, expWrites: 4, expAccepts: 2};
      table0[5] = '{nop: 1, chi: 200, base: 16'h7FFF, rdyMode: 2, extraVld: 0, expWrites: 8, expAccepts: 4};

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("reset cfgRdy", cfgRdy, 1'b1);
      checkOutput("reset ofmRdy", ofmRdy, 1'b0);
      checkOutput("reset wrVld", wrVld, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset wrAddr", wrAddr, 16'h0);
      checkOutput("reset wrDat", wrDat, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (table0[i]) runLayer(table0[i]);

      // Random layers against the model.
      for (int r = 0; r < 4; r++) begin
         lv.nop        = $urandom_range(0, 3);
         lv.chi        = $urandom_range(1, 256);
         lv.base       = 16'($urandom());
         lv.rdyMode    = 2;
         lv.extraVld   = 1'($urandom_range(0, 1));
         lv.expAccepts = lv.nop * ((lv.chi + 63) / 64);
         lv.expWrites  = lv.expAccepts * (VW / SW);
         runLayer(lv);
      end

      // Soft reset after beat 0 of vector 1: stall GLB so beat 1 is pending.
      rdyMode = 0;
      clearCounters();
      modelLayer(2, 16'h0200, vecs);
      void'(expQ.pop_back());
      applyStimulus(2, 64, 16'h0200);
      sendVector(vecs[0]);
      sendVector(vecs[1]);
      ofmVld = 1'b0;
      guard = 0;
      while (writeCnt < 3 && guard < 50) begin
         @(posedge clk); #2;
         guard++;
      end
      checkOutput("rst writes before", writeCnt, 3);
      ccuRst  = 1'b1;
      rdyMode = 3;
      wrRdy   = 1'b0;
      @(posedge clk); #1;
      ccuRst = 1'b0;
      @(negedge clk);
      checkOutput("rst wrVld", wrVld, 1'b0);
      checkOutput("rst cfgRdy", cfgRdy, 1'b1);
      rdyMode = 0;
      repeat (10) @(negedge clk);
      checkOutput("rst no done", doneCnt, 0);
      checkOutput("rst no more writes", writeCnt, 3);
      checkOutput("rst expected left", expQ.size(), 0);
      expQ.delete();
      runLayer('{nop: 1, chi: 64, base: 16'h0300, rdyMode: 0, extraVld: 0, expWrites: 2, expAccepts: 1});

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation ran out of time");
      $fatal(1, "watchdog");
   end

endmodule
